// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array operand feeder.
package systolic_feeder_pkg;

   localparam int unsigned DEF_N = 3;
   localparam int unsigned DEF_W = 8;

   // Cycles from the start-accept cycle to the done cycle for the default size.
   localparam int unsigned LATENCY = 3 * DEF_N - 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Width of a row/column index for an n x n matrix.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of the step counter; it must hold 0 .. 2n-2.
   function automatic int unsigned step_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(2 * n);
   endfunction

   // Start-to-done latency for an arbitrary array size.
   function automatic int unsigned feed_latency(input int unsigned n);
      return 3 * n - 1;
   endfunction

endpackage

// File: rtl/systolic_feeder_skew_mux.sv
// Diagonal skew selector: picks, per edge lane, the matrix element due at step t.
module systolic_feeder_skew_mux
   import systolic_feeder_pkg::*;
#(
   parameter int unsigned N         = DEF_N,
   parameter int unsigned W         = DEF_W,
   parameter int unsigned TW        = step_w(DEF_N),
   parameter bit          COL_MAJOR = 1'b0
) (
   input  logic [N*N*W-1:0] mat,
   input  logic [TW-1:0]    t,
   output logic [N*W-1:0]   edge_vec
);

   // Lane i carries element k = t - i of its row (A) or column (B), else zero.
   always_comb begin
      edge_vec = '0;
      for (int i = 0; i < int'(N); i++) begin
         if ((int'(t) >= i) && ((int'(t) - i) < int'(N))) begin
            if (COL_MAJOR)
               edge_vec[i*W +: W] = mat[(((int'(t) - i) * int'(N)) + i) * int'(W) +: W];
            else
               edge_vec[i*W +: W] = mat[((i * int'(N)) + (int'(t) - i)) * int'(W) +: W];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic MAC array: stores A and B, then streams
// them onto the array edges with a one-cycle-per-lane diagonal skew.
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int unsigned N = DEF_N,
   parameter int unsigned W = DEF_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic                  load_sel,
   input  logic [idx_w(N)-1:0]   load_row,
   input  logic [idx_w(N)-1:0]   load_col,
   input  logic [W-1:0]          load_data,
   input  logic                  start,
   output logic [N*W-1:0]        a_edge,
   output logic [N*W-1:0]        b_edge,
   output logic                  acc_clr,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned TW         = step_w(N);
   localparam int unsigned FEED_LAST  = 2 * N - 2;
   // Drain is sized so done lands feed_latency(N) cycles after start acceptance.
   localparam int unsigned DRAIN_LEN  = (N > 2) ? N - 2 : 0;
   localparam int unsigned DRAIN_LAST = (DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0;

   state_t              state;
   logic [TW-1:0]       t;
   logic [TW-1:0]       skew_t;
   logic [N*N*W-1:0]    mat_a;
   logic [N*N*W-1:0]    mat_b;
   logic [N*W-1:0]      a_next;
   logic [N*W-1:0]      b_next;
   logic                load_hit;
   int unsigned         load_base;

   // Step whose operands are presented in the cycle after the coming edge.
   assign skew_t = (state == ST_FEED) ? t + TW'(1) : '0;

   assign load_hit  = load_en && (state == ST_IDLE) &&
                      (32'(load_row) < N) && (32'(load_col) < N);
   assign load_base = ((32'(load_row) * N) + 32'(load_col)) * W;

   systolic_feeder_skew_mux #(.N(N), .W(W), .TW(TW), .COL_MAJOR(1'b0)) u_skew_a (
      .mat      (mat_a),
      .t        (skew_t),
      .edge_vec (a_next)
   );

   systolic_feeder_skew_mux #(.N(N), .W(W), .TW(TW), .COL_MAJOR(1'b1)) u_skew_b (
      .mat      (mat_b),
      .t        (skew_t),
      .edge_vec (b_next)
   );

   // Operand storage; writes are accepted only while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mat_a <= '0;
         mat_b <= '0;
      end else if (load_hit) begin
         if (load_sel)
            mat_b[load_base +: W] <= load_data;
         else
            mat_a[load_base +: W] <= load_data;
      end
   end

   // Run sequencer with registered edge operands and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         t       <= '0;
         a_edge  <= '0;
         b_edge  <= '0;
         acc_clr <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         acc_clr <= 1'b0;
         done    <= 1'b0;
         a_edge  <= '0;
         b_edge  <= '0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_CLEAR;
                  acc_clr <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            ST_CLEAR: begin
               state  <= ST_FEED;
               t      <= '0;
               a_edge <= a_next;
               b_edge <= b_next;
            end
            ST_FEED: begin
               if (t == TW'(FEED_LAST)) begin
                  t <= '0;
                  if (DRAIN_LEN == 0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end else begin
                  t      <= t + TW'(1);
                  a_edge <= a_next;
                  b_edge <= b_next;
               end
            end
            ST_DRAIN: begin
               if (t == TW'(DRAIN_LAST)) begin
                  t     <= '0;
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  t <= t + TW'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               t     <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N = 3, W = 8).
module tb_systolic_feeder;
   import systolic_feeder_pkg::*;

   localparam int unsigned N   = 3;
   localparam int unsigned W   = 8;
   localparam int unsigned IW  = 2;
   localparam int          LAT = 3 * N - 1;

   typedef struct packed {
      logic           clr;
      logic           busy;
      logic           done;
      logic [N*W-1:0] a;
      logic [N*W-1:0] b;
   } obs_t;

   typedef struct {
      logic       clr, busy, done;
      logic [7:0] a0, a1, a2, b0, b1, b2;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           load_en;
   logic           load_sel;
   logic [IW-1:0]  load_row;
   logic [IW-1:0]  load_col;
   logic [W-1:0]   load_data;
   logic           start;
   logic [N*W-1:0] a_edge;
   logic [N*W-1:0] b_edge;
   logic           acc_clr;
   logic           busy;
   logic           done;

   int checks = 0;
   int errors = 0;
   int ma[N][N];
   int mb[N][N];
   int acc[N][N];
   int ar[N][N];
   int br[N][N];
   vec_t tbl[9];

   always #5 clk = ~clk;

   systolic_feeder #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_en),
      .load_sel  (load_sel),
      .load_row  (load_row),
      .load_col  (load_col),
      .load_data (load_data),
      .start     (start),
      .a_edge    (a_edge),
      .b_edge    (b_edge),
      .acc_clr   (acc_clr),
      .busy      (busy),
      .done      (done)
   );

   // Behavioural N x N MAC array fed by the edges, one register per hop.
   task automatic mac_step();
      int na[N][N];
      int nb[N][N];
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            na[i][j] = (j == 0) ? int'(a_edge[i*W +: W]) : ar[i][j-1];
            nb[i][j] = (i == 0) ? int'(b_edge[j*W +: W]) : br[i-1][j];
         end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc[i][j] = acc_clr ? 0 : ((acc[i][j] + na[i][j] * nb[i][j]) & 255);
            ar[i][j]  = na[i][j];
            br[i][j]  = nb[i][j];
         end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      mac_step();
   endtask

   // Expected outputs d cycles after start acceptance (d = 0: idle).
   function automatic obs_t model_at(input int d);
      obs_t o;
      o = '0;
      o.busy = (d >= 1 && d <= LAT);
      o.clr  = (d == 1);
      o.done = (d == LAT);
      if (d >= 2 && d <= 2 * N) begin
         int t;
         t = d - 2;
         for (int i = 0; i < N; i++) begin
            int k;
            k = t - i;
            if (k >= 0 && k < N) begin
               o.a[i*W +: W] = W'(ma[i][k]);
               o.b[i*W +: W] = W'(mb[k][i]);
            end
         end
      end
      return o;
   endfunction

   task automatic check(input string name, input obs_t exp);
      obs_t got;
      got = {acc_clr, busy, done, a_edge, b_edge};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got clr=%0b busy=%0b done=%0b a=%h b=%h want clr=%0b busy=%0b done=%0b a=%h b=%h",
                  name, got.clr, got.busy, got.done, got.a, got.b,
                  exp.clr, exp.busy, exp.done, exp.a, exp.b);
      end
   endtask

   task automatic check_mac(input string name);
      int  want;
      bit  ok;
      int  bi, bj, bg, bw;
      ok = 1'b1;
      bi = 0; bj = 0; bg = 0; bw = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            want = 0;
            for (int k = 0; k < N; k++)
               want += ma[i][k] * mb[k][j];
            want &= 255;
            if (ok && acc[i][j] != want) begin
               ok = 1'b0;
               bi = i; bj = j; bg = acc[i][j]; bw = want;
            end
         end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s cell(%0d,%0d) got %0d want %0d", name, bi, bj, bg, bw);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic load(input bit sel, input int r, input int c, input int v);
      load_en   = 1'b1;
      load_sel  = sel;
      load_row  = IW'(r);
      load_col  = IW'(c);
      load_data = W'(v);
      tick();
      load_en = 1'b0;
      if (r < N && c < N) begin
         if (sel) mb[r][c] = v;
         else     ma[r][c] = v;
      end
   endtask

   task automatic load_a_seq();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            load(1'b0, r, c, r * N + c + 1);
   endtask

   task automatic load_b_ident();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            load(1'b1, r, c, (r == c) ? 1 : 0);
   endtask

   // Start in the current cycle and check every cycle up to done.
   task automatic run_checked(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int d = 1; d <= LAT; d++) begin
         check($sformatf("%s_d%0d", tag, d), model_at(d));
         if (d < LAT) tick();
      end
   endtask

   // Start in the current cycle and compare against the hand-written table.
   task automatic run_table(input string tag);
      obs_t e;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         e.clr  = tbl[i].clr;
         e.busy = tbl[i].busy;
         e.done = tbl[i].done;
         e.a    = {tbl[i].a2, tbl[i].a1, tbl[i].a0};
         e.b    = {tbl[i].b2, tbl[i].b1, tbl[i].b0};
         check($sformatf("%s_c%0d", tag, i + 1), e);
         if (i < 8) tick();
      end
   endtask

   initial begin
      //         clr   busy  done  a0 a1 a2  b0 b1 b2
      tbl[0] = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 1, 0, 0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 2, 4, 0, 0, 0, 0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 3, 5, 7, 0, 1, 0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 0, 6, 8, 0, 0, 0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 0, 0, 9, 0, 0, 1};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
      tbl[7] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};

      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = 0; mb[i][j] = 0; acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
         end

      rst = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_row = '0;
      load_col = '0; load_data = '0; start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset", model_at(0));
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("idle%0d", c), model_at(0));
      end

      // Basic stream with A = 1..9, B = identity, then a back-to-back rerun.
      load_a_seq();
      load_b_ident();
      run_table("ident");
      check_mac("ident_mac");
      run_table("b2b");
      check_mac("b2b_mac");

      // Array-level result with B = 9..1.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            load(1'b1, r, c, 9 - (r * N + c));
      run_checked("prod");
      check_int("out00", acc[0][0], 30);
      check_int("out22", acc[2][2], 90);
      check_mac("prod_mac");
      tick();
      check("prod_idle", model_at(0));

      // start and load_en while busy are ignored, including start during done.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int d = 1; d <= LAT; d++) begin
         check($sformatf("busyin_d%0d", d), model_at(d));
         start     = (d == 3 || d == LAT);
         load_en   = (d == 4);
         load_sel  = 1'b0;
         load_row  = '0;
         load_col  = '0;
         load_data = 8'd55;
         tick();
      end
      start   = 1'b0;
      load_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("busyin_after%0d", c), model_at(0));
         tick();
      end
      run_checked("persist");
      tick();

      // Out-of-range indices must not alias into the arrays.
      load(1'b0, 3, 0, 77);
      load(1'b0, 0, 3, 77);
      load(1'b1, 3, 3, 77);
      run_checked("oor");
      tick();

      // Reset at FEED t = 2 wins over start and load_en, and clears storage.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int d = 1; d <= 4; d++) begin
         check($sformatf("abort_d%0d", d), model_at(d));
         if (d < 4) tick();
      end
      rst = 1'b1; start = 1'b1; load_en = 1'b1; load_sel = 1'b0;
      load_row = 2'd1; load_col = 2'd1; load_data = 8'd200;
      tick();
      rst = 1'b0; start = 1'b0; load_en = 1'b0;
      check("abort_rst", model_at(0));
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 0; mb[r][c] = 0;
         end
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("abort_idle%0d", c), model_at(0));
      end
      run_checked("zeroed");
      tick();
      load_a_seq();
      load_b_ident();
      run_table("reload");

      // Randomised matrices against the reference model.
      for (int it = 0; it < 4; it++) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               load(1'b0, r, c, int'($urandom_range(0, 255)));
               load(1'b1, r, c, int'($urandom_range(0, 255)));
            end
         repeat ($urandom_range(0, 3)) tick();
         run_checked($sformatf("rnd%0d", it));
         check_mac($sformatf("rnd%0d_mac", it));
         tick();
         check($sformatf("rnd%0d_idle", it), model_at(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
